dram_burst_writer: RTL

- Downstream stage of the UDP frame receiver; consumes its DRAM write stream (36-bit strobe+data words, 40-bit len+addr commands) and emits AXI4 write bursts to the DRAM controller.
- Buffers data and commands in internal FIFOs, splits bursts at 4 KB boundaries, and runs one AXI transaction at a time.
- Reports overflow and write-response errors as sticky flags.

---
 rtl/dram_burst_writer_if.sv | 43 ++++
 rtl/dram_burst_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_writer_if.sv
// rtl/dram_burst_writer_if.sv - AXI4 write-channel bundle between dram_burst_writer and the DRAM controller
// Purpose: groups the AW, W and B channels of one AXI4 write port.
// Ports (signals):
//   AW: m_awaddr[ADDR_WIDTH], m_awlen[8], m_awsize[3], m_awburst[2], m_awvalid, m_awready
//   W : m_wdata[32], m_wstrb[4], m_wlast, m_wvalid, m_wready
//   B : m_bresp[2], m_bvalid, m_bready
// Modports: master (burst writer side), slave (DRAM controller side).
interface dram_burst_writer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize;
  logic [1:0]            m_awburst;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [31:0]           m_wdata;
  logic [3:0]            m_wstrb;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/dram_burst_writer.sv
// rtl/dram_burst_writer.sv - buffers a word/command write stream and issues 4 KB-safe AXI4 write bursts
// Purpose: data and command FIFOs feeding a single-outstanding AXI4 write engine.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   data_in[36], data_we {strb, data} word push
//   ctrl_in[40], ctrl_we {len in words, byte addr} command push
//   m                   AXI4 write port (dram_burst_writer_if.master)
//   busy                engine active or commands pending
//   data_ovf, ctrl_ovf  sticky: word / command dropped on a full FIFO
//   cmd_err, resp_err   sticky: len>64 clipped / non-OKAY write response
module dram_burst_writer #(
  parameter int DATA_DEPTH = 1024,
  parameter int CTRL_DEPTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [35:0]           data_in,
  input  logic                  data_we,
  input  logic [39:0]           ctrl_in,
  input  logic                  ctrl_we,
  dram_burst_writer_if.master   m,
  output logic                  busy,
  output logic                  data_ovf,
  output logic                  ctrl_ovf,
  output logic                  cmd_err,
  output logic                  resp_err
);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CAW = $clog2(CTRL_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_AW, S_W, S_B} state_t;
  state_t state_q, state_d;

  // Data FIFO (first-word-fall-through)
  logic [35:0]  d_mem [DATA_DEPTH];
  logic [DAW-1:0] d_wptr, d_rptr;
  logic [DAW:0]   d_count;
  logic d_full, d_pop, d_push;
  logic [35:0] d_head;

  // Command FIFO (first-word-fall-through)
  logic [39:0]  c_mem [CTRL_DEPTH];
  logic [CAW-1:0] c_wptr, c_rptr;
  logic [CAW:0]   c_count;
  logic c_full, c_empty, c_pop, c_push;
  logic [39:0] c_head;

  // Burst engine state
  logic [6:0]            rem_q, beats_q, beat_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr, aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [12:0]           room_bytes;
  logic [10:0]           room_words;
  logic [6:0]            beats_calc, len_clip;
  logic                  load_go;

  assign d_full  = (d_count == (DAW+1)'(DATA_DEPTH));
  assign d_head  = d_mem[d_rptr];
  assign d_pop   = m.m_wvalid && m.m_wready;
  // A full FIFO still accepts a push when a word leaves in the same cycle.
  assign d_push  = data_we && (!d_full || d_pop);

  assign c_full  = (c_count == (CAW+1)'(CTRL_DEPTH));
  assign c_empty = (c_count == '0);
  assign c_head  = c_mem[c_rptr];
  assign c_push  = ctrl_we && (!c_full || c_pop);

  always_ff @(posedge clk) begin
    if (d_push) d_mem[d_wptr] <= data_in;
    if (c_push) c_mem[c_wptr] <= ctrl_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wptr <= '0; d_rptr <= '0; d_count <= '0;
      c_wptr <= '0; c_rptr <= '0; c_count <= '0;
      data_ovf <= 1'b0; ctrl_ovf <= 1'b0;
    end else begin
      if (d_push) d_wptr <= d_wptr + DAW'(1);
      if (d_pop)  d_rptr <= d_rptr + DAW'(1);
      if (d_push && !d_pop) d_count <= d_count + (DAW+1)'(1);
      else if (!d_push && d_pop) d_count <= d_count - (DAW+1)'(1);
      if (c_push) c_wptr <= c_wptr + CAW'(1);
      if (c_pop)  c_rptr <= c_rptr + CAW'(1);
      if (c_push && !c_pop) c_count <= c_count + (CAW+1)'(1);
      else if (!c_push && c_pop) c_count <= c_count - (CAW+1)'(1);
      if (data_we && !d_push) data_ovf <= 1'b1;
      if (ctrl_we && !c_push) ctrl_ovf <= 1'b1;
    end
  end

  assign len_clip = (c_head[39:32] > 8'd64) ? 7'd64 : c_head[38:32];

  // Words left before the next 4 KB page; at least 1 since addresses are word aligned.
  assign room_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
  assign room_words = room_bytes[12:2];
  assign beats_calc = ({4'b0, rem_q} < room_words) ? rem_q : room_words[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    c_pop       = 1'b0;
    load_go     = 1'b0;
    m.m_awvalid = 1'b0;
    m.m_wvalid  = 1'b0;
    m.m_wlast   = 1'b0;
    m.m_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!c_empty) begin
          c_pop = 1'b1;
          if (c_head[39:32] != 8'd0) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Only start once the whole burst is buffered so W never stalls.
        if (d_count >= (DAW+1)'(beats_calc)) begin
          load_go = 1'b1;
          state_d = S_AW;
        end
      end
      S_AW: begin
        m.m_awvalid = 1'b1;
        if (m.m_awready) state_d = S_W;
      end
      S_W: begin
        m.m_wvalid = 1'b1;
        m.m_wlast  = (beat_cnt == beats_q - 7'd1);
        if (m.m_wready && m.m_wlast) state_d = S_B;
      end
      S_B: begin
        m.m_bready = 1'b1;
        if (m.m_bvalid) state_d = (rem_q == beats_q) ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      beats_q   <= '0;
      beat_cnt  <= '0;
      cur_addr  <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      cmd_err   <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (c_pop && c_head[39:32] != 8'd0) begin
        rem_q    <= len_clip;
        cur_addr <= ADDR_WIDTH'({c_head[31:2], 2'b00});
        if (c_head[39:32] > 8'd64) cmd_err <= 1'b1;
      end
      if (load_go) begin
        beats_q   <= beats_calc;
        aw_addr_q <= cur_addr;
        aw_len_q  <= {1'b0, beats_calc} - 8'd1;
        beat_cnt  <= '0;
      end
      if (d_pop) beat_cnt <= beat_cnt + 7'd1;
      if (state_q == S_B && m.m_bvalid) begin
        if (m.m_bresp != 2'b00) resp_err <= 1'b1;
        rem_q    <= rem_q - beats_q;
        cur_addr <= cur_addr + ADDR_WIDTH'({beats_q, 2'b00});
      end
    end
  end

  assign m.m_awaddr  = aw_addr_q;
  assign m.m_awlen   = aw_len_q;
  assign m.m_awsize  = 3'b010;
  assign m.m_awburst = 2'b01;
  assign m.m_wdata   = m.m_wvalid ? d_head[31:0]  : 32'd0;
  assign m.m_wstrb   = m.m_wvalid ? d_head[35:32] : 4'd0;
  assign busy        = (state_q != S_IDLE) || !c_empty;
endmodule
